// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic operand protocol: feeder FSM states and
// the default operand width also used by the MAC PE.
package systolic_pkg;

    localparam int SYS_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SKEW_WAIT = 3'd2,
        STREAM    = 3'd3,
        FINISH    = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/systolic_edge_feeder_if.sv
// Host-write and PE-stream signals of one systolic edge lane, bundled with
// modports for the feeder (slave) and whatever drives it (master).
interface systolic_edge_feeder_if #(
    parameter int DATA_WIDTH = systolic_pkg::SYS_DATA_WIDTH
) ();

    // Host side: a word moves on a rising clk edge where wr_valid & wr_ready;
    // wr_data/wr_last are held with wr_valid until then. PE side: a word moves
    // on a rising edge where out_waiting & out_ready; out_data/out_waiting stay
    // stable until then, and out_finished is held until an edge sees out_ready.
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_last;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_waiting;
    logic                  out_ready;
    logic                  out_finished;

    modport master (
        output wr_data, wr_valid, wr_last, out_ready,
        input  wr_ready, out_data, out_waiting, out_finished
    );

    modport slave (
        input  wr_data, wr_valid, wr_last, out_ready,
        output wr_ready, out_data, out_waiting, out_finished
    );

endinterface

// File: rtl/operand_fifo.sv
// Small synchronous FIFO holding one operand vector; pointers carry an extra
// wrap bit so full and empty are distinguished without a separate counter.
module operand_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing is read before it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/systolic_edge_feeder.sv
// Edge feeder for one systolic lane: latches a host vector, waits SKEW idle
// cycles, streams it to the first PE, then raises finished until acknowledged.
module systolic_edge_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = SYS_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int SKEW       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    systolic_edge_feeder_if.slave   bus,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  vec_len,
    output logic [2:0]              dbg_state
);

    localparam int LEN_W = $clog2(DEPTH) + 1;

    localparam logic [2:0] S_IDLE      = IDLE;
    localparam logic [2:0] S_LOAD      = LOAD;
    localparam logic [2:0] S_SKEW_WAIT = SKEW_WAIT;
    localparam logic [2:0] S_STREAM    = STREAM;
    localparam logic [2:0] S_FINISH    = FINISH;

    logic [2:0]            state_q, state_d;
    logic [3:0]            skew_cnt_q, skew_cnt_d;
    logic [LEN_W-1:0]      vec_len_q, vec_len_d;
    logic                  out_waiting_q, out_waiting_d;
    logic                  out_finished_q, out_finished_d;
    logic                  alive_q;
    logic                  wr_ready;
    logic                  accept;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [LEN_W-1:0]      fifo_count;

    // alive_q keeps wr_ready low until the first edge after reset release.
    assign wr_ready = alive_q & ((state_q == S_IDLE) |
                                 ((state_q == S_LOAD) & ~fifo_full));
    assign accept   = bus.wr_valid & wr_ready;
    assign pop      = (state_q == S_STREAM) & out_waiting_q & bus.out_ready & ~fifo_empty;

    operand_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (bus.wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d        = state_q;
        skew_cnt_d     = skew_cnt_q;
        vec_len_d      = vec_len_q;
        out_waiting_d  = out_waiting_q;
        out_finished_d = out_finished_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    vec_len_d = LEN_W'(1);
                    if (bus.wr_last) begin
                        state_d    = S_SKEW_WAIT;
                        skew_cnt_d = 4'(SKEW);
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    vec_len_d = vec_len_q + LEN_W'(1);
                    // A full buffer ends the vector even without wr_last.
                    if (bus.wr_last || (vec_len_d == LEN_W'(DEPTH))) begin
                        state_d    = S_SKEW_WAIT;
                        skew_cnt_d = 4'(SKEW);
                    end
                end
            end
            S_SKEW_WAIT: begin
                if (skew_cnt_q == 4'd0) begin
                    state_d = S_STREAM;
                end else begin
                    skew_cnt_d = skew_cnt_q - 4'd1;
                end
            end
            S_STREAM: begin
                // First STREAM cycle only raises waiting; the data is the FIFO head.
                if (!out_waiting_q) begin
                    out_waiting_d = 1'b1;
                end else if (bus.out_ready && (fifo_count == LEN_W'(1))) begin
                    out_waiting_d  = 1'b0;
                    out_finished_d = 1'b1;
                    state_d        = S_FINISH;
                end
            end
            S_FINISH: begin
                if (bus.out_ready) begin
                    out_finished_d = 1'b0;
                    vec_len_d      = '0;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                state_d        = S_IDLE;
                out_waiting_d  = 1'b0;
                out_finished_d = 1'b0;
                vec_len_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            skew_cnt_q     <= '0;
            vec_len_q      <= '0;
            out_waiting_q  <= 1'b0;
            out_finished_q <= 1'b0;
            alive_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            skew_cnt_q     <= skew_cnt_d;
            vec_len_q      <= vec_len_d;
            out_waiting_q  <= out_waiting_d;
            out_finished_q <= out_finished_d;
            alive_q        <= 1'b1;
        end
    end

    assign bus.wr_ready     = wr_ready;
    assign bus.out_data     = out_waiting_q ? fifo_head : '0;
    assign bus.out_waiting  = out_waiting_q;
    assign bus.out_finished = out_finished_q;
    assign busy             = (state_q != S_IDLE);
    assign vec_len          = vec_len_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Bench for systolic_edge_feeder: two lanes (skew 0 and 3), directed vectors,
// expected words queued at acceptance and compared by per-lane monitors.
module tb_systolic_edge_feeder;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_edge_feeder_if #(.DATA_WIDTH(DW)) bus0 ();
    systolic_edge_feeder_if #(.DATA_WIDTH(DW)) bus1 ();

    logic       busy0, busy1;
    logic [3:0] vec_len0, vec_len1;
    logic [2:0] dbg0, dbg1;

    systolic_edge_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SKEW(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus0),
        .busy      (busy0),
        .vec_len   (vec_len0),
        .dbg_state (dbg0)
    );

    systolic_edge_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SKEW(3)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .busy      (busy1),
        .vec_len   (vec_len1),
        .dbg_state (dbg1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp0_q[$];
    logic [DW-1:0] exp1_q[$];
    bit rp [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    logic          stall0 = 1'b0, stall1 = 1'b0;
    logic [DW-1:0] held0 = '0, held1 = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall0 <= 1'b0;
        end else begin
            if (stall0) begin
                check("hold_waiting0", bus0.out_waiting, 1);
                check("hold_data0", bus0.out_data, held0);
            end
            if (bus0.out_finished) check("fin_excl0", bus0.out_waiting, 0);
            if (bus0.out_waiting && bus0.out_ready) begin
                if (exp0_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_word0: got %0h required no word", bus0.out_data);
                end else begin
                    check("data0", bus0.out_data, exp0_q.pop_front());
                end
            end
            stall0 <= bus0.out_waiting & ~bus0.out_ready;
            held0  <= bus0.out_data;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall1 <= 1'b0;
        end else begin
            if (stall1) begin
                check("hold_waiting1", bus1.out_waiting, 1);
                check("hold_data1", bus1.out_data, held1);
            end
            if (bus1.out_finished) check("fin_excl1", bus1.out_waiting, 0);
            if (bus1.out_waiting && bus1.out_ready) begin
                if (exp1_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_word1: got %0h required no word", bus1.out_data);
                end else begin
                    check("data1", bus1.out_data, exp1_q.pop_front());
                end
            end
            stall1 <= bus1.out_waiting & ~bus1.out_ready;
            held1  <= bus1.out_data;
        end
    end

    // ---------------- drivers ----------------
    task automatic push_word(input bit sel, input logic [DW-1:0] d, input bit last,
                             output int pre_q, output bit pre_busy);
        int  t  = 0;
        bit  ok = 1'b0;
        pre_q    = -1;
        pre_busy = 1'b1;
        if (sel) begin
            bus1.wr_data = d; bus1.wr_valid = 1'b1; bus1.wr_last = last;
        end else begin
            bus0.wr_data = d; bus0.wr_valid = 1'b1; bus0.wr_last = last;
        end
        while (t < 200 && !ok) begin
            @(negedge clk);
            if (sel ? bus1.wr_ready : bus0.wr_ready) ok = 1'b1;
            else t++;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: got wr_ready=0 required 1 within 200 cycles");
        end else if (sel) begin
            pre_q = exp1_q.size(); pre_busy = busy1; exp1_q.push_back(d);
        end else begin
            pre_q = exp0_q.size(); pre_busy = busy0; exp0_q.push_back(d);
        end
        @(posedge clk); #1;
        if (sel) begin
            bus1.wr_valid = 1'b0; bus1.wr_last = 1'b0;
        end else begin
            bus0.wr_valid = 1'b0; bus0.wr_last = 1'b0;
        end
    endtask

    // Counts posedges from the current point until out_waiting is seen high.
    task automatic wait_waiting(input bit sel, output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (!(sel ? busy1 : busy0)) busy_ok = 1'b0;
            if (sel ? bus1.out_waiting : bus0.out_waiting) break;
        end
    endtask

    task automatic drain(input bit sel);
        int t = 0;
        while (t < 300 && (((sel ? exp1_q.size() : exp0_q.size()) != 0) || (sel ? busy1 : busy0))) begin
            @(posedge clk); #1;
            t++;
        end
        check(sel ? "drain1" : "drain0", 64'(t < 300), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        bit bok;
        int pq;
        bit pb;
        bus0.wr_data = '0; bus0.wr_valid = 1'b0; bus0.wr_last = 1'b0; bus0.out_ready = 1'b1;
        bus1.wr_data = '0; bus1.wr_valid = 1'b0; bus1.wr_last = 1'b0; bus1.out_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_ready0", bus0.wr_ready, 0);
        check("rst_wr_ready1", bus1.wr_ready, 0);
        check("rst_out_data", bus0.out_data, 0);
        check("rst_waiting", bus0.out_waiting, 0);
        check("rst_finished", bus0.out_finished, 0);
        check("rst_busy", busy0, 0);
        check("rst_vec_len", vec_len0, 0);
        check("rst_state", dbg0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("wr_ready_after_rst", bus0.wr_ready, 1);

        // K=4, SKEW=0, out_ready=1
        push_word(0, 32'h11, 0, pq, pb);
        push_word(0, 32'h22, 0, pq, pb);
        push_word(0, 32'h33, 0, pq, pb);
        push_word(0, 32'h44, 1, pq, pb);
        check("vec_len_k4", vec_len0, 4);
        check("wr_ready_skew_wait", bus0.wr_ready, 0);
        wait_waiting(0, lat, bok);
        check("latency_k4", lat, 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("waiting_run_k4", bus0.out_waiting, 1);
        end
        @(negedge clk);
        check("finished_k4", bus0.out_finished, 1);
        check("waiting_off_k4", bus0.out_waiting, 0);
        @(negedge clk);
        check("finished_1cyc_k4", bus0.out_finished, 0);
        check("idle_busy_k4", busy0, 0);
        check("idle_vec_len_k4", vec_len0, 0);
        @(posedge clk); #1;

        // SKEW=3, K=2
        push_word(1, 32'h55, 0, pq, pb);
        push_word(1, 32'h66, 1, pq, pb);
        wait_waiting(1, lat, bok);
        check("latency_skew3", lat, 5);
        check("busy_skew3", bok, 1);
        drain(1);

        // 9 words, no wr_last: forced last at DEPTH
        for (int i = 1; i <= 8; i++) push_word(0, 32'h100 + i, 0, pq, pb);
        check("vec_len_forced", vec_len0, 8);
        check("wr_ready_forced", bus0.wr_ready, 0);
        push_word(0, 32'h109, 1, pq, pb);
        check("word9_after_drain", pq, 0);
        check("word9_in_idle", pb, 0);
        drain(0);

        // Backpressure 1,0,0,1 then finished held while out_ready=0
        push_word(0, 32'hB1, 0, pq, pb);
        push_word(0, 32'hB2, 0, pq, pb);
        push_word(0, 32'hB3, 1, pq, pb);
        wait_waiting(0, lat, bok);
        check("latency_bp", lat, 2);
        for (int i = 0; i < 8; i++) begin
            bus0.out_ready = rp[i];
            @(negedge clk);
            if (i >= 5) check("finished_held_bp", bus0.out_finished, 1);
            @(posedge clk); #1;
        end
        bus0.out_ready = 1'b1;
        @(negedge clk);
        check("finished_release_bp", bus0.out_finished, 0);
        check("idle_bp", busy0, 0);
        check("no_loss_bp", exp0_q.size(), 0);
        @(posedge clk); #1;

        // Reset in the middle of STREAM after 2 of 5 words
        for (int i = 1; i <= 5; i++) push_word(0, 32'hC0 + i, (i == 5), pq, pb);
        wait_waiting(0, lat, bok);
        check("latency_k5", lat, 2);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        check("words_left_at_rst", exp0_q.size(), 3);
        exp0_q.delete();
        #1;
        check("midrst_waiting", bus0.out_waiting, 0);
        check("midrst_data", bus0.out_data, 0);
        check("midrst_finished", bus0.out_finished, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_vec_len", vec_len0, 0);
        check("midrst_wr_ready", bus0.wr_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("wr_ready_after_midrst", bus0.wr_ready, 1);
        push_word(0, 32'hAB, 1, pq, pb);
        check("vec_len_k1", vec_len0, 1);
        wait_waiting(0, lat, bok);
        check("latency_after_rst", lat, 2);
        drain(0);

        // K=1, out_ready low for 3 cycles
        bus0.out_ready = 1'b0;
        push_word(0, 32'hDEAD, 1, pq, pb);
        wait_waiting(0, lat, bok);
        check("latency_dead", lat, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("waiting_held_dead", bus0.out_waiting, 1);
            @(posedge clk); #1;
        end
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        check("waiting_drop_dead", bus0.out_waiting, 0);
        check("finished_dead", bus0.out_finished, 1);
        @(posedge clk); #1;
        check("finished_clear_dead", bus0.out_finished, 0);
        check("idle_dead", busy0, 0);
        check("no_loss_dead", exp0_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/systolic_edge_feeder.md
# systolic_edge_feeder

Transmit-side endpoint of the systolic operand protocol (data / waiting / ready / finished). One instance drives one array edge lane (one row of A or one column of B) into the first MAC PE of that lane. The block buffers one operand vector written by the host, inserts a per-lane skew delay, streams the words into the PE under the ready/waiting handshake, then signals end-of-vector with finished.

## Interface
- DATA_WIDTH, 32, operand width; matches the PE.
- DEPTH, 8, maximum vector length K in words; power of two, ≥2.
- SKEW, 0, idle cycles inserted before the first word; equals the lane index, 0..15.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low; deassertion is synchronous to clk.
- wr_data  in  DATA_WIDTH  host operand word.
- wr_valid  in  1  host word valid.
- wr_last  in  1  marks the final word of the vector; qualified by wr_valid.
- wr_ready  out  1  block accepts a host word.
- out_data  out  DATA_WIDTH  operand to PE (A_in/B_in).
- out_waiting  out  1  out_data valid (PE *_in_waiting).
- out_ready  in  1  PE can take a word (PE *_in_ready).
- out_finished  out  1  end of vector (PE *_in_finished).
- busy  out  1  block is not in IDLE.
- vec_len  out  $clog2(DEPTH)+1  number of words latched for the current vector.

## Operation
- States: IDLE, LOAD, SKEW_WAIT, STREAM, FINISH.
- IDLE: wr_ready=1. An accepted word (wr_valid&wr_ready) is pushed to the FIFO and vec_len is set to 1. The next state is LOAD, or SKEW_WAIT if wr_last=1.
- LOAD: wr_ready=1 when the FIFO is not full. Each accept pushes a word and increments vec_len.
  - An accept with wr_last, or the accept that reaches DEPTH words (forced last), moves to SKEW_WAIT.
  - Host words arriving after a forced last wait until the block returns to IDLE.
- SKEW_WAIT: wr_ready=0. A down-counter is loaded with SKEW. When it reaches 0, the state moves to STREAM. With SKEW=0 this state lasts exactly 1 cycle.
- STREAM: out_waiting=1 and out_data=FIFO head.
  - A transfer occurs at a posedge where out_waiting&out_ready=1; that transfer pops the FIFO.
  - While out_ready=0, out_data and out_waiting are held stable.
  - After the transfer that pops the last word, out_waiting drops on the next cycle and the state moves to FINISH.
- FINISH: out_finished=1 and out_waiting=0. out_finished is held until a posedge samples out_ready=1, then the state moves to IDLE. vec_len clears to 0 on entry to IDLE.
- wr_ready is 0 in SKEW_WAIT, STREAM and FINISH. The FIFO never underflows, because STREAM exits when the popped count equals vec_len.
- Widths: vec_len counts 0..DEPTH. The skew counter is 4 bits. No arithmetic is performed on the data.

## Timing
- All outputs are registered or decoded from state/FIFO registers; no combinational path from out_ready to outputs. wr_ready may depend combinationally on FIFO full.
- Reset values: wr_ready=0 while rst_n=0 and 1 from the first cycle after release. All other outputs are 0: out_data, out_waiting, out_finished, busy, vec_len.
- Latency, last host word accepted to first out_waiting: SKEW+2 cycles.
- Throughput: 1 word/cycle while out_ready=1.
- Last transfer to out_finished high: 1 cycle. Minimum FINISH duration: 1 cycle.
- Reset mid-operation (any state) clears the state, FIFO pointers, counters and outputs immediately; the partial vector is discarded.
- Simultaneous events:
  - wr_valid while in STREAM is ignored (wr_ready=0).
  - out_ready together with the last word's waiting completes that transfer; finished follows on the next cycle, never in the same cycle as waiting.

## Structure
- Shared package systolic_pkg: feeder_state_t enum (IDLE, LOAD, SKEW_WAIT, STREAM, FINISH) and the DATA_WIDTH default constant, shared with the PE.
- Sub-module operand_fifo (DATA_WIDTH, DEPTH):
  - synchronous push/pop, full/empty flags, count;
  - pointers one bit wider than the address for wrap detection;
  - async active-low reset.
- Top level holds the FSM, skew counter and vec_len.

## Test plan
- K=4 words 0x11,0x22,0x33,0x44, SKEW=0, out_ready=1 → out_waiting rises 2 cycles after wr_last; out_data is 0x11..0x44 on 4 consecutive cycles; out_finished is high for 1 cycle; then IDLE with vec_len=0.
- SKEW=3, K=2 → first out_waiting occurs 5 cycles after the last accept; busy=1 throughout.
- DEPTH=8, 9 words written with no wr_last → wr_ready drops after word 8; vec_len=8; 8 words stream out; word 9 is accepted only after the return to IDLE.
- Backpressure: out_ready toggles 1,0,0,1 during STREAM → out_data is held stable while out_ready=0; no word is lost or duplicated; out_finished is held until out_ready=1.
- rst_n pulsed low in the middle of STREAM after 2 of 5 words → all outputs are 0 during reset; a new K=1 vector 0xAB streams correctly with no stale data.
- K=1 vector 0xDEAD, out_ready=0 for 3 cycles → out_waiting is held 3 cycles, the transfer happens on the 4th, and finished follows on the next cycle.
